// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard receiver in the system clock domain.
// Synchronises and glitch-filters the raw PS/2 lines, frames 11-bit packets,
// folds E0/F0 prefixes into per-key flags and queues events in a FWFT FIFO.
// Optional: define PS2_PARITY_EN to reject bytes with bad odd parity.
module ps2_scan_rx #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 20000,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       rd,
   output logic       valid,
   output logic [7:0] code,
   output logic       ext,
   output logic       brk,
   output logic       frame_err,
   output logic       overflow
);

   localparam int FCW = $clog2(FILTER_LEN);
   localparam int TCW = $clog2(TIMEOUT_CYC + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic           clkMeta_q, clkSync_q, dataMeta_q, dataSync_q;
   logic           filtClk_q;
   logic [FCW-1:0] filtCnt_q;
   logic           sampleEvt;

   state_t         state_q;
   logic [2:0]     bitCnt_q;
   logic [7:0]     shift_q;
   logic [TCW-1:0] timer_q;
   logic           extFlag_q, brkFlag_q;
   logic           pushReq_q;
   logic [9:0]     pushData_q;
   logic           frameErr_q;
   logic           timeoutHit;
   logic           parityBad;

   logic [9:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wrPtr_q, rdPtr_q;
   logic [AW:0]    count_q, count_d;
   logic           overflow_q;
   logic           doRd, doWr, full;

`ifdef PS2_PARITY_EN
   logic           parity_q;
   assign parityBad = ~(^{shift_q, parity_q});
`else
   assign parityBad = 1'b0;
`endif

   // Two-flop synchronisers; lines idle high so reset them high
   always_ff @(posedge clk) begin
      if (rst) begin
         clkMeta_q  <= 1'b1;
         clkSync_q  <= 1'b1;
         dataMeta_q <= 1'b1;
         dataSync_q <= 1'b1;
      end else begin
         clkMeta_q  <= ps2_clk;
         clkSync_q  <= clkMeta_q;
         dataMeta_q <= ps2_data;
         dataSync_q <= dataMeta_q;
      end
   end

   // Glitch filter: the FILTER_LEN-th consecutive differing sample flips the level
   always_ff @(posedge clk) begin
      if (rst) begin
         filtClk_q <= 1'b1;
         filtCnt_q <= '0;
      end else if (clkSync_q == filtClk_q) begin
         filtCnt_q <= '0;
      end else if (filtCnt_q == FCW'(FILTER_LEN - 1)) begin
         filtClk_q <= clkSync_q;
         filtCnt_q <= '0;
      end else begin
         filtCnt_q <= filtCnt_q + 1'b1;
      end
   end

   // A sample event is the cycle in which the filtered clock falls
   assign sampleEvt  = filtClk_q & ~clkSync_q & (filtCnt_q == FCW'(FILTER_LEN - 1));
   assign timeoutHit = (state_q != IDLE) && !sampleEvt && (timer_q == TCW'(TIMEOUT_CYC - 1));

   // Frame FSM with timeout, prefix folding and registered push/error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         timer_q    <= '0;
         extFlag_q  <= 1'b0;
         brkFlag_q  <= 1'b0;
         pushReq_q  <= 1'b0;
         pushData_q <= '0;
         frameErr_q <= 1'b0;
`ifdef PS2_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         pushReq_q  <= 1'b0;
         frameErr_q <= 1'b0;
         if (state_q == IDLE || sampleEvt) begin
            timer_q <= '0;
         end else begin
            timer_q <= timer_q + 1'b1;
         end
         if (timeoutHit) begin
            state_q    <= IDLE;
            frameErr_q <= 1'b1;
         end else if (sampleEvt) begin
            case (state_q)
               IDLE: begin
                  if (!dataSync_q) begin
                     state_q  <= DATA;
                     bitCnt_q <= '0;
                  end
               end
               DATA: begin
                  shift_q  <= {dataSync_q, shift_q[7:1]};
                  bitCnt_q <= bitCnt_q + 1'b1;
                  if (bitCnt_q == 3'd7) begin
                     state_q <= PARITY;
                  end
               end
               PARITY: begin
`ifdef PS2_PARITY_EN
                  parity_q <= dataSync_q;
`endif
                  state_q <= STOP;
               end
               STOP: begin
                  state_q <= IDLE;
                  if (!dataSync_q || parityBad) begin
                     frameErr_q <= 1'b1;
                  end else if (shift_q == 8'hE0) begin
                     extFlag_q <= 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     brkFlag_q <= 1'b1;
                  end else begin
                     pushReq_q  <= 1'b1;
                     pushData_q <= {extFlag_q, brkFlag_q, shift_q};
                     extFlag_q  <= 1'b0;
                     brkFlag_q  <= 1'b0;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign full = (count_q == (AW + 1)'(FIFO_DEPTH));
   assign doRd = rd && (count_q != '0);
   assign doWr = pushReq_q && (!full || doRd);

   // Occupancy next-state from the accepted read/write pair
   always_comb begin
      count_d = count_q;
      if (doWr && !doRd) begin
         count_d = count_q + 1'b1;
      end else if (!doWr && doRd) begin
         count_d = count_q - 1'b1;
      end
   end

   // FIFO pointers, occupancy and the dropped-event pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         overflow_q <= pushReq_q && full && !doRd;
         if (doWr) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (doRd) begin
            rdPtr_q <= rdPtr_q + 1'b1;
         end
      end
   end

   // FIFO storage needs no reset; outputs are masked while empty
   always_ff @(posedge clk) begin
      if (doWr) begin
         mem_q[wrPtr_q] <= pushData_q;
      end
   end

   assign valid     = (count_q != '0);
   assign code      = valid ? mem_q[rdPtr_q][7:0] : 8'h00;
   assign ext       = valid ? mem_q[rdPtr_q][9] : 1'b0;
   assign brk       = valid ? mem_q[rdPtr_q][8] : 1'b0;
   assign frame_err = frameErr_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: directed bench for ps2_scan_rx, bit-banging PS/2 frames
// and checking decoded events, error and overflow pulses.
module tb_ps2_scan_rx;

   localparam int FILT  = 8;
   localparam int TMO   = 2000;
   localparam int DEPTH = 4;
   localparam int HALF  = 20;

   logic       clk = 1'b0;
   logic       rst, ps2_clk, ps2_data, rd;
   logic       valid, ext, brk, frame_err, overflow;
   logic [7:0] code;

   int testsRun    = 0;
   int testsFailed = 0;
   int errCnt      = 0;
   int ovfCnt      = 0;
   int e0, o0;

   ps2_scan_rx #(
      .FILTER_LEN (FILT),
      .TIMEOUT_CYC(TMO),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rd       (rd),
      .valid    (valid),
      .code     (code),
      .ext      (ext),
      .brk      (brk),
      .frame_err(frame_err),
      .overflow (overflow)
   );

   // 10-unit system clock
   always #5 clk = ~clk;

   // Tally error and overflow pulses as they happen
   always @(posedge clk) begin
      if (frame_err) errCnt++;
      if (overflow)  ovfCnt++;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sendBit(input logic b);
      ps2_data = b;
      waitCycles(HALF);
      ps2_clk = 1'b0;
      waitCycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic glitchClk();
      ps2_clk = 1'b0;
      waitCycles(FILT - 1);
      ps2_clk = 1'b1;
      waitCycles(HALF);
   endtask

   // Full frame with odd parity, optionally inverted; glitch after data bit glitchAt
   task automatic applyStimulus(input logic [7:0] val, input logic badPar, input int glitchAt);
      logic par;
      par = (~^val) ^ badPar;
      sendBit(1'b0);
      for (int i = 0; i < 8; i++) begin
         sendBit(val[i]);
         if (i == glitchAt) glitchClk();
      end
      sendBit(par);
      sendBit(1'b1);
      ps2_data = 1'b1;
      waitCycles(HALF);
   endtask

   task automatic expectHead(input string tag, input logic [7:0] c, input logic x, input logic b);
      checkOutput({tag, "_valid"}, valid, 1'b1);
      checkOutput({tag, "_code"}, code, c);
      checkOutput({tag, "_ext"}, ext, x);
      checkOutput({tag, "_brk"}, brk, b);
      rd = 1'b1;
      waitCycles(1);
      rd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0;
      waitCycles(3);
      checkOutput("rst_valid", valid, 1'b0);
      checkOutput("rst_code", code, 8'h00);
      checkOutput("rst_ext", ext, 1'b0);
      checkOutput("rst_brk", brk, 1'b0);
      checkOutput("rst_ferr", frame_err, 1'b0);
      checkOutput("rst_ovf", overflow, 1'b0);
      rst = 1'b0;
      waitCycles(HALF);

      // Plain make code, then pop
      applyStimulus(8'h1C, 1'b0, -1);
      expectHead("t1", 8'h1C, 1'b0, 1'b0);
      checkOutput("t1_empty", valid, 1'b0);
      checkOutput("t1_noerr", errCnt, 0);

      // Prefix folding
      applyStimulus(8'hF0, 1'b0, -1);
      checkOutput("t2_prefix_nopush", valid, 1'b0);
      applyStimulus(8'h1C, 1'b0, -1);
      applyStimulus(8'hE0, 1'b0, -1);
      applyStimulus(8'hF0, 1'b0, -1);
      applyStimulus(8'h75, 1'b0, -1);
      expectHead("t2a", 8'h1C, 1'b0, 1'b1);
      expectHead("t2b", 8'h75, 1'b1, 1'b1);
      checkOutput("t2_empty", valid, 1'b0);
      applyStimulus(8'hF0, 1'b0, -1);
      applyStimulus(8'hE0, 1'b0, -1);
      applyStimulus(8'h74, 1'b0, -1);
      expectHead("t2c", 8'h74, 1'b1, 1'b1);

      // Parity handling
      e0 = errCnt;
      applyStimulus(8'h29, 1'b1, -1);
`ifdef PS2_PARITY_EN
      checkOutput("t3_bad_err", errCnt - e0, 1);
      checkOutput("t3_bad_valid", valid, 1'b0);
`else
      checkOutput("t3_bad_err", errCnt - e0, 0);
      expectHead("t3_bad", 8'h29, 1'b0, 1'b0);
`endif
      applyStimulus(8'h29, 1'b0, -1);
      expectHead("t3_good", 8'h29, 1'b0, 1'b0);

      // Stalled frame times out once
      e0 = errCnt;
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b1);
      ps2_data = 1'b1;
      waitCycles(TMO - 50);
      checkOutput("t4_early", errCnt - e0, 0);
      waitCycles(60);
      checkOutput("t4_timeout", errCnt - e0, 1);
      checkOutput("t4_valid", valid, 1'b0);
      applyStimulus(8'h1D, 1'b0, -1);
      expectHead("t4_after", 8'h1D, 1'b0, 1'b0);
      checkOutput("t4_single", errCnt - e0, 1);

      // Overflow on the fifth push
      o0 = ovfCnt;
      applyStimulus(8'h15, 1'b0, -1);
      applyStimulus(8'h1C, 1'b0, -1);
      applyStimulus(8'h1B, 1'b0, -1);
      applyStimulus(8'h23, 1'b0, -1);
      checkOutput("t5_no_ovf", ovfCnt - o0, 0);
      applyStimulus(8'h2B, 1'b0, -1);
      checkOutput("t5_ovf", ovfCnt - o0, 1);
      expectHead("t5_r0", 8'h15, 1'b0, 1'b0);
      expectHead("t5_r1", 8'h1C, 1'b0, 1'b0);
      expectHead("t5_r2", 8'h1B, 1'b0, 1'b0);
      expectHead("t5_r3", 8'h23, 1'b0, 1'b0);
      checkOutput("t5_empty", valid, 1'b0);

      // Short clock glitches are ignored in IDLE and in DATA
      e0 = errCnt;
      ps2_data = 1'b0;
      glitchClk();
      ps2_data = 1'b1;
      waitCycles(HALF);
      applyStimulus(8'h1C, 1'b0, 3);
      expectHead("t6", 8'h1C, 1'b0, 1'b0);
      checkOutput("t6_empty", valid, 1'b0);
      checkOutput("t6_noerr", errCnt - e0, 0);

      // Reset mid-frame drops the partial frame silently
      e0 = errCnt;
      sendBit(1'b0);
      sendBit(1'b1);
      sendBit(1'b1);
      rst = 1'b1;
      waitCycles(2);
      rst = 1'b0;
      waitCycles(HALF);
      applyStimulus(8'h2B, 1'b0, -1);
      expectHead("t7", 8'h2B, 1'b0, 1'b0);
      waitCycles(TMO + 10);
      checkOutput("t7_noerr", errCnt - e0, 0);
      checkOutput("t7_empty", valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ps2_scan_rx.md
Name: ps2_scan_rx

Overview:
Parametrised PS/2 keyboard receiver running entirely in the system clock domain. It oversamples the raw PS/2 clock and data lines, filters glitches, and frames 11-bit packets. It also checks start, stop and parity bits, times out stalled frames, and folds E0 (extended) and F0 (break) prefixes into per-key flags. Decoded key events are buffered in a small first-word-fall-through (FWFT) FIFO for the game-control logic (snake direction decoder) to consume.

Parameters:
FILTER_LEN, 8, consecutive identical samples required before the filtered ps2_clk changes level (min 2)
TIMEOUT_CYC, 20000, system cycles without a filtered falling edge before an in-progress frame is abandoned
FIFO_DEPTH, 4, event FIFO entries (power of 2, min 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
ps2_clk  input  1  raw keyboard clock (asynchronous)
ps2_data  input  1  raw keyboard data (asynchronous)
rd  input  1  pop the FIFO head; ignored when valid=0
valid  output  1  FIFO not empty; code/ext/brk hold the head entry
code  output  8  scan code of the head entry
ext  output  1  head entry was preceded by E0
brk  output  1  head entry was preceded by F0 (key release)
frame_err  output  1  one-cycle pulse on a framing, parity or timeout error
overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset values: valid=0, code=0, ext=0, brk=0, frame_err=0, overflow=0.
- Reset clears the FIFO, the prefix flags, the bit counter and the filter state; the filtered clock resets to 1.
- Reset mid-frame discards the partial frame with no frame_err.
- Input conditioning:
  - 2-flop synchroniser on both ps2_clk and ps2_data.
  - Filtered clock changes only after FILTER_LEN consecutive equal synchronised samples.
  - A sample event is a 1->0 transition of the filtered clock. Synchronised data is sampled in that same cycle.
- Frame FSM states:
  - IDLE: on a sample event, data=0 -> DATA with bit count 0. Data=1 is a spurious start: stay in IDLE, no error.
  - DATA: 8 sample events, bits shifted LSB first. After the 8th -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: on a sample event -> IDLE. Data=0 -> frame_err, byte discarded. Data=1 -> byte complete (subject to the parity check).
- Timeout:
  - Counter cleared on every sample event and while in IDLE.
  - In DATA, PARITY or STOP, reaching TIMEOUT_CYC -> IDLE, frame_err pulse, byte discarded. Prefix flags are kept.
- Prefix folding on a complete byte:
  - 8'hE0: set the ext flag, push nothing.
  - 8'hF0: set the brk flag, push nothing.
  - Any other byte: push {ext_flag, brk_flag, byte}, then clear both flags in the same cycle.
  - Flags are independent, so "E0 F0 xx" and "F0 E0 xx" both give ext=1, brk=1.
- Latency: a push occurs in the cycle after the stop-bit sample event, and valid/code are visible the following cycle.
- FIFO (FWFT, entry width 10):
  - Push while full (and no rd in the same cycle): entry dropped, overflow pulses, FIFO unchanged.
  - rd and push in the same cycle when full: both accepted, count unchanged.
  - rd and push in the same cycle when empty: push accepted, rd ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- frame_err and overflow may pulse in the same cycle; the two are independent.

Optional Feature:
PS2_PARITY_EN
- Defined: odd parity is checked, i.e. the 8 data bits plus the parity bit must contain an odd number of 1s.
  - On a mismatch, the byte is discarded at the stop sample and frame_err pulses.
  - The byte is not used for prefix folding.
- Undefined: the parity bit is sampled and ignored; no parity-based frame_err.

Test Plan:
- Frame 0x1C with parity=0 and stop=1, then rd one cycle after valid -> valid=1, code=8'h1C, ext=0, brk=0; valid=0 after rd.
- Frames F0,1C then E0,F0,75 -> two entries: {ext=0,brk=1,1C} then {ext=1,brk=1,75}. No entries for the prefixes.
- With PS2_PARITY_EN: frame 0x29 with parity=1 -> frame_err pulses once, valid stays 0. Then a correct 0x29 frame -> code=8'h29.
- Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYC+10 cycles -> exactly one frame_err pulse. A following 0x1D frame decodes as code=8'h1D.
- 5 frames 0x15,0x1C,0x1B,0x23,0x2B with FIFO_DEPTH=4 and no rd -> overflow pulses at the 5th push. Four reads return 15,1C,1B,23 in order, then valid=0.
- ps2_clk low glitch of FILTER_LEN-1 cycles while in IDLE, and a glitch during DATA -> no sample event, no state change. A subsequent 0x1C frame decodes correctly.
